// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: drives the sram0 address and buffers {pc, instr} pairs.
// The oldest entry is presented to the fetch stage, and a redirect flushes the queue.
module inst_prefetch_queue #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   input  logic [DATA_WIDTH-1:0]     mem_data,
   input  logic                      fetch_en,
   input  logic                      redirect,
   input  logic [ADDR_WIDTH-1:0]     redirect_pc,
   output logic                      inst_valid,
   input  logic                      inst_ready,
   output logic [DATA_WIDTH-1:0]     inst_out,
   output logic [ADDR_WIDTH-1:0]     inst_pc,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      cnt;
   logic [ADDR_WIDTH-1:0] q_pc   [DEPTH];
   logic [DATA_WIDTH-1:0] q_inst [DEPTH];
   logic                  not_empty;
   logic                  pop;
   logic                  push;

   assign not_empty = (cnt != '0);
   assign pop       = not_empty & inst_ready;
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign push      = fetch_en & ~redirect & ((cnt < CNT_W'(DEPTH)) | pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         cnt      <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            q_pc[i]   <= '0;
            q_inst[i] <= '0;
         end
      end else if (redirect) begin
         fetch_pc <= redirect_pc;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         cnt      <= '0;
      end else begin
         if (push) begin
            q_pc[wr_ptr]   <= fetch_pc;
            q_inst[wr_ptr] <= mem_data;
            wr_ptr         <= wr_ptr + PTR_W'(1);
            fetch_pc       <= fetch_pc + ADDR_WIDTH'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign mem_addr   = fetch_pc;
   assign inst_valid = not_empty;
   assign inst_out   = not_empty ? q_inst[rd_ptr] : '0;
   assign inst_pc    = not_empty ? q_pc[rd_ptr]   : '0;
   assign count      = cnt;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed self-checking bench for inst_prefetch_queue with an async sram0 model.
module tb_inst_prefetch_queue;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic        fetch_en;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [15:0] inst_out;
   logic [15:0] inst_pc;
   logic [2:0]  count;

   int tests_run = 0;
   int tests_failed = 0;

   inst_prefetch_queue #(
      .ADDR_WIDTH (16),
      .DATA_WIDTH (16),
      .DEPTH      (4),
      .RESET_PC   (16'h0000)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .fetch_en    (fetch_en),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_out    (inst_out),
      .inst_pc     (inst_pc),
      .count       (count)
   );

   always #5 clk = ~clk;

   // sram0 contents: fixed words at 0..7, a simple pattern elsewhere.
   function automatic logic [15:0] mem_fn(input logic [15:0] a);
      case (a)
         16'd0:   mem_fn = 16'h7800;
         16'd1:   mem_fn = 16'h2005;
         16'd2:   mem_fn = 16'h3006;
         16'd3:   mem_fn = 16'h1004;
         16'd4:   mem_fn = 16'h7400;
         16'd5:   mem_fn = 16'h4010;
         16'd6:   mem_fn = 16'h6020;
         16'd7:   mem_fn = 16'h5300;
         default: mem_fn = a ^ 16'hC3C3;
      endcase
   endfunction

   assign mem_data = mem_fn(mem_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // advance one rising edge and land on the following falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_empty(input string tag, input logic [15:0] addr);
      check({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
      check({tag, "_count"}, {29'd0, count}, 32'd0);
      check({tag, "_out"}, {16'd0, inst_out}, 32'd0);
      check({tag, "_pc"}, {16'd0, inst_pc}, 32'd0);
      check({tag, "_addr"}, {16'd0, mem_addr}, {16'd0, addr});
   endtask

   initial begin
      reset_n     = 1'b0;
      fetch_en    = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      inst_ready  = 1'b0;
      @(negedge clk);
      check_empty("reset", 16'h0000);
      @(negedge clk);

      // fill with no consumer: count 1,2,3,4 then saturates
      reset_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         check($sformatf("fill_count%0d", i), {29'd0, count}, (i > 4) ? 32'd4 : 32'(i));
      end
      check("fill_valid", {31'd0, inst_valid}, 32'd1);
      check("fill_addr", {16'd0, mem_addr}, 32'd4);
      check("fill_out", {16'd0, inst_out}, 32'h7800);
      check("fill_pc", {16'd0, inst_pc}, 32'd0);

      // full queue with a one-cycle pop: push and pop together
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      check("fullpp_pc", {16'd0, inst_pc}, 32'd1);
      check("fullpp_out", {16'd0, inst_out}, 32'h2005);
      check("fullpp_count", {29'd0, count}, 32'd4);
      check("fullpp_addr", {16'd0, mem_addr}, 32'd5);

      // two more push/pop cycles leave pc 3..6 queued
      inst_ready = 1'b1;
      step();
      step();
      inst_ready = 1'b0;
      check("pre_redir_pc", {16'd0, inst_pc}, 32'd3);
      check("pre_redir_count", {29'd0, count}, 32'd4);
      check("pre_redir_addr", {16'd0, mem_addr}, 32'd7);

      // redirect: one bubble then the new stream
      redirect    = 1'b1;
      redirect_pc = 16'h0040;
      step();
      redirect = 1'b0;
      check_empty("redir", 16'h0040);
      step();
      check("redir_valid", {31'd0, inst_valid}, 32'd1);
      check("redir_pc", {16'd0, inst_pc}, 32'h0040);
      check("redir_out", {16'd0, inst_out}, 32'hC383);
      check("redir_count", {29'd0, count}, 32'd1);

      // redirect with a concurrent pop, then address wrap while streaming
      redirect    = 1'b1;
      redirect_pc = 16'hFFFE;
      inst_ready  = 1'b1;
      step();
      redirect = 1'b0;
      check_empty("wrap_redir", 16'hFFFE);
      step();
      check("wrap_pc0", {16'd0, inst_pc}, 32'hFFFE);
      check("wrap_out0", {16'd0, inst_out}, 32'h3C3D);
      step();
      check("wrap_pc1", {16'd0, inst_pc}, 32'hFFFF);
      step();
      check("wrap_pc2", {16'd0, inst_pc}, 32'h0000);
      check("wrap_out2", {16'd0, inst_out}, 32'h7800);
      check("wrap_count", {29'd0, count}, 32'd1);
      check("wrap_addr", {16'd0, mem_addr}, 32'd1);

      // fetch_en low: drain and hold the address
      fetch_en = 1'b0;
      step();
      check_empty("fen_off1", 16'h0001);
      step();
      check_empty("fen_off2", 16'h0001);
      fetch_en = 1'b1;
      step();
      check("fen_on_pc", {16'd0, inst_pc}, 32'd1);
      check("fen_on_out", {16'd0, inst_out}, 32'h2005);
      check("fen_on_addr", {16'd0, mem_addr}, 32'd2);

      // async reset between edges with three entries queued
      reset_n    = 1'b0;
      inst_ready = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      step();
      step();
      step();
      check("mid_count_pre", {29'd0, count}, 32'd3);
      #2;
      reset_n = 1'b0;
      #1;
      check_empty("async_rst", 16'h0000);
      @(negedge clk);

      // streaming from reset with the consumer always ready
      inst_ready = 1'b1;
      reset_n    = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("stream_pc%0d", i), {16'd0, inst_pc}, 32'(i));
         check($sformatf("stream_out%0d", i), {16'd0, inst_out}, {16'd0, mem_fn(16'(i))});
         check($sformatf("stream_count%0d", i), {29'd0, count}, 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
